game_seq_ctrl: RTL and testbench

//  Top-level game sequencer for the ghost/pac datapath. Owns the round FSM (idle, ready, play, dying, over, win).

---
 rtl/game_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq_ctrl.sv
// Round sequencer for the ghost/pac datapath: round FSM, ghost release, scatter/chase scheduling, lives.
// Optional frightened mode is enabled by defining GHOST_FRIGHT_EN.
module game_seq_ctrl #(
    parameter int NUM_GHOSTS    = 4,
    parameter int LIVES         = 3,
    parameter int READY_TICKS   = 60,
    parameter int RELEASE_TICKS = 30,
    parameter int SCATTER_TICKS = 140,
    parameter int CHASE_TICKS   = 400,
    parameter int FRIGHT_TICKS  = 120,
    parameter int DEATH_TICKS   = 90
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_s,
    input  logic                  start,
    input  logic [NUM_GHOSTS-1:0] p_dead,
    input  logic                  pellet_clr,
    input  logic                  power_eaten,
    output logic [2:0]            state,
    output logic                  pac_en,
    output logic [NUM_GHOSTS-1:0] ghost_en,
    output logic [NUM_GHOSTS-1:0] ghost_rst,
    output logic [1:0]            ghost_mode,
    output logic [2:0]            lives,
    output logic                  game_over,
    output logic                  win
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_DYING = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;

    localparam logic [1:0] M_SCAT   = 2'd0;
    localparam logic [1:0] M_CHASE  = 2'd1;
    localparam logic [1:0] M_FRIGHT = 2'd2;

    localparam logic [9:0] READY_LAST = 10'(READY_TICKS - 1);
    localparam logic [9:0] REL_LAST   = 10'(RELEASE_TICKS - 1);
    localparam logic [9:0] SCAT_LAST  = 10'(SCATTER_TICKS - 1);
    localparam logic [9:0] CHASE_LAST = 10'(CHASE_TICKS - 1);
    localparam logic [9:0] DEATH_LAST = 10'(DEATH_TICKS - 1);
    localparam logic [3:0] IDX_LAST   = 4'(NUM_GHOSTS - 1);
    localparam logic [2:0] LIVES_V    = 3'(LIVES);

    localparam logic [NUM_GHOSTS-1:0] GE_ONE = NUM_GHOSTS'(1);

    logic       cs_q1;
    logic       cs_q2;
    logic       cs_q3;
    logic       start_q;
    logic       tick;
    logic       start_rise;
    logic       go_ready;
    logic [9:0] tmr;
    logic [9:0] rel_tmr;
    logic [3:0] rel_idx;
    logic [9:0] ph_tmr;

`ifdef GHOST_FRIGHT_EN
    localparam logic [9:0] FRIGHT_V = 10'(FRIGHT_TICKS);

    logic [NUM_GHOSTS-1:0] p_dead_q;
    logic [9:0]            fr_tmr;
    logic [1:0]            mode_sv;
`endif

    // clk_s is asynchronous to clk: two-flop sync, third flop for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q1   <= 1'b0;
            cs_q2   <= 1'b0;
            cs_q3   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            cs_q1   <= clk_s;
            cs_q2   <= cs_q1;
            cs_q3   <= cs_q2;
            start_q <= start;
        end
    end

    assign tick       = cs_q2 & ~cs_q3;
    assign start_rise = start & ~start_q;

    assign go_ready =
        ((state == S_IDLE) || (state == S_OVER) || (state == S_WIN))
            ? start_rise
            : ((state == S_DYING) && tick && (tmr == DEATH_LAST) && (lives != 3'd0));

`ifdef GHOST_FRIGHT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_dead_q <= '0;
        end else begin
            p_dead_q <= p_dead;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pac_en     <= 1'b0;
            ghost_en   <= '0;
            ghost_rst  <= '0;
            ghost_mode <= M_SCAT;
            lives      <= LIVES_V;
            game_over  <= 1'b0;
            win        <= 1'b0;
            tmr        <= '0;
            rel_tmr    <= '0;
            rel_idx    <= '0;
            ph_tmr     <= '0;
`ifdef GHOST_FRIGHT_EN
            fr_tmr     <= '0;
            mode_sv    <= M_SCAT;
`endif
        end else begin
            ghost_rst <= '0;
            unique case (state)
                S_IDLE, S_OVER, S_WIN: begin
                    pac_en   <= 1'b0;
                    ghost_en <= '0;
                end
                S_READY: begin
                    if (tick) begin
                        if (tmr == READY_LAST) begin
                            state    <= S_PLAY;
                            tmr      <= '0;
                            pac_en   <= 1'b1;
                            ghost_en <= GE_ONE;
                            rel_tmr  <= '0;
                            rel_idx  <= '0;
                        end else begin
                            tmr <= tmr + 10'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (pellet_clr) begin
                        state      <= S_WIN;
                        win        <= 1'b1;
                        pac_en     <= 1'b0;
                        ghost_en   <= '0;
                        ghost_mode <= M_SCAT;
                        tmr        <= '0;
                    end else if ((|p_dead) && (ghost_mode != M_FRIGHT)) begin
                        state      <= S_DYING;
                        lives      <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                        pac_en     <= 1'b0;
                        ghost_en   <= '0;
                        ghost_mode <= M_SCAT;
                        tmr        <= '0;
                    end else begin
                        if (tick && (rel_idx < IDX_LAST)) begin
                            if (rel_tmr == REL_LAST) begin
                                rel_tmr  <= '0;
                                rel_idx  <= rel_idx + 4'd1;
                                ghost_en <= ghost_en | (GE_ONE << (rel_idx + 4'd1));
                            end else begin
                                rel_tmr <= rel_tmr + 10'd1;
                            end
                        end
`ifdef GHOST_FRIGHT_EN
                        // phase timer stays frozen while frightened
                        if (ghost_mode == M_FRIGHT) begin
                            ghost_rst <= p_dead & ~p_dead_q;
                            if (power_eaten) begin
                                fr_tmr <= FRIGHT_V;
                            end else if (tick) begin
                                if (fr_tmr <= 10'd1) begin
                                    fr_tmr     <= '0;
                                    ghost_mode <= mode_sv;
                                end else begin
                                    fr_tmr <= fr_tmr - 10'd1;
                                end
                            end
                        end else if (power_eaten) begin
                            mode_sv    <= ghost_mode;
                            ghost_mode <= M_FRIGHT;
                            fr_tmr     <= FRIGHT_V;
                        end else
`endif
                        if (tick) begin
                            if (ghost_mode == M_SCAT) begin
                                if (ph_tmr == SCAT_LAST) begin
                                    ph_tmr     <= '0;
                                    ghost_mode <= M_CHASE;
                                end else begin
                                    ph_tmr <= ph_tmr + 10'd1;
                                end
                            end else begin
                                if (ph_tmr == CHASE_LAST) begin
                                    ph_tmr     <= '0;
                                    ghost_mode <= M_SCAT;
                                end else begin
                                    ph_tmr <= ph_tmr + 10'd1;
                                end
                            end
                        end
                    end
                end
                S_DYING: begin
                    pac_en   <= 1'b0;
                    ghost_en <= '0;
                    if (tick) begin
                        if (tmr == DEATH_LAST) begin
                            tmr <= '0;
                            if (lives == 3'd0) begin
                                state     <= S_OVER;
                                game_over <= 1'b1;
                            end
                        end else begin
                            tmr <= tmr + 10'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // common entry into READY from start or a survived death
            if (go_ready) begin
                state      <= S_READY;
                ghost_rst  <= '1;
                pac_en     <= 1'b0;
                ghost_en   <= '0;
                ghost_mode <= M_SCAT;
                tmr        <= '0;
                ph_tmr     <= '0;
                rel_tmr    <= '0;
                rel_idx    <= '0;
                game_over  <= 1'b0;
                win        <= 1'b0;
`ifdef GHOST_FRIGHT_EN
                fr_tmr     <= '0;
                mode_sv    <= M_SCAT;
`endif
                if (state != S_DYING) begin
                    lives <= LIVES_V;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl: round flow, ghost release, phase schedule, deaths, win, reset.
module tb_game_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       clk_s;
    logic       start;
    logic [3:0] p_dead;
    logic       pellet_clr;
    logic       power_eaten;
    logic [2:0] state;
    logic       pac_en;
    logic [3:0] ghost_en;
    logic [3:0] ghost_rst;
    logic [1:0] ghost_mode;
    logic [2:0] lives;
    logic       game_over;
    logic       win;

    int n_checks = 0;
    int n_pass   = 0;

    game_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clk_s       (clk_s),
        .start       (start),
        .p_dead      (p_dead),
        .pellet_clr  (pellet_clr),
        .power_eaten (power_eaten),
        .state       (state),
        .pac_en      (pac_en),
        .ghost_en    (ghost_en),
        .ghost_rst   (ghost_rst),
        .ghost_mode  (ghost_mode),
        .lives       (lives),
        .game_over   (game_over),
        .win         (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one slow tick; returns one clk after the DUT has acted on it
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            clk_s = 1'b0;
            repeat (2) @(negedge clk);
            clk_s = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic press_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", state); else n_pass++;
        n_checks++; if (pac_en !== 1'b0 || ghost_en !== 4'b0000) $display("FAIL rst_en got=%b/%b exp=0/0000", pac_en, ghost_en); else n_pass++;
        n_checks++; if (ghost_rst !== 4'b0000) $display("FAIL rst_grst got=%b exp=0000", ghost_rst); else n_pass++;
        n_checks++; if (ghost_mode !== 2'd0) $display("FAIL rst_mode got=%0d exp=0", ghost_mode); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL rst_lives got=%0d exp=3", lives); else n_pass++;
        n_checks++; if (game_over !== 1'b0 || win !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", game_over, win); else n_pass++;
        rst = 1'b1;
        tick_n(3);
        n_checks++; if (state !== 3'd0) $display("FAIL idle_hold got=%0d exp=0", state); else n_pass++;
    endtask

    task automatic test_release_modes();
        press_start();
        n_checks++; if (state !== 3'd1) $display("FAIL t2_ready got=%0d exp=1", state); else n_pass++;
        n_checks++; if (ghost_rst !== 4'b1111) $display("FAIL t2_grst got=%b exp=1111", ghost_rst); else n_pass++;
        @(negedge clk);
        n_checks++; if (ghost_rst !== 4'b0000) $display("FAIL t2_grst_clr got=%b exp=0000", ghost_rst); else n_pass++;
        tick_n(59);
        n_checks++; if (state !== 3'd1) $display("FAIL t2_ready59 got=%0d exp=1", state); else n_pass++;
        tick_n(1);
        n_checks++; if (state !== 3'd2) $display("FAIL t2_play got=%0d exp=2", state); else n_pass++;
        n_checks++; if (pac_en !== 1'b1) $display("FAIL t2_pac got=%b exp=1", pac_en); else n_pass++;
        n_checks++; if (ghost_en !== 4'b0001) $display("FAIL t2_ge0 got=%b exp=0001", ghost_en); else n_pass++;
        tick_n(29);
        n_checks++; if (ghost_en !== 4'b0001) $display("FAIL t2_ge29 got=%b exp=0001", ghost_en); else n_pass++;
        tick_n(1);
        n_checks++; if (ghost_en !== 4'b0011) $display("FAIL t2_ge30 got=%b exp=0011", ghost_en); else n_pass++;
        tick_n(30);
        n_checks++; if (ghost_en !== 4'b0111) $display("FAIL t2_ge60 got=%b exp=0111", ghost_en); else n_pass++;
        tick_n(30);
        n_checks++; if (ghost_en !== 4'b1111) $display("FAIL t2_ge90 got=%b exp=1111", ghost_en); else n_pass++;
        tick_n(49);
        n_checks++; if (ghost_mode !== 2'd0) $display("FAIL t2_mode139 got=%0d exp=0", ghost_mode); else n_pass++;
        tick_n(1);
        n_checks++; if (ghost_mode !== 2'd1) $display("FAIL t2_mode140 got=%0d exp=1", ghost_mode); else n_pass++;
        tick_n(399);
        n_checks++; if (ghost_mode !== 2'd1) $display("FAIL t2_mode539 got=%0d exp=1", ghost_mode); else n_pass++;
        tick_n(1);
        n_checks++; if (ghost_mode !== 2'd0) $display("FAIL t2_mode540 got=%0d exp=0", ghost_mode); else n_pass++;
        n_checks++; if (ghost_en !== 4'b1111) $display("FAIL t2_ge_sticky got=%b exp=1111", ghost_en); else n_pass++;
    endtask

    task automatic test_death();
        p_dead = 4'b0100;
        @(negedge clk);
        p_dead = 4'b0000;
        n_checks++; if (state !== 3'd3) $display("FAIL t3_dying got=%0d exp=3", state); else n_pass++;
        n_checks++; if (lives !== 3'd2) $display("FAIL t3_lives got=%0d exp=2", lives); else n_pass++;
        n_checks++; if (pac_en !== 1'b0 || ghost_en !== 4'b0000) $display("FAIL t3_en got=%b/%b exp=0/0000", pac_en, ghost_en); else n_pass++;
        press_start();
        tick_n(89);
        n_checks++; if (state !== 3'd3) $display("FAIL t3_dying89 got=%0d exp=3", state); else n_pass++;
        tick_n(1);
        n_checks++; if (state !== 3'd1) $display("FAIL t3_ready got=%0d exp=1", state); else n_pass++;
        n_checks++; if (ghost_rst !== 4'b1111) $display("FAIL t3_grst got=%b exp=1111", ghost_rst); else n_pass++;
        @(negedge clk);
        n_checks++; if (ghost_rst !== 4'b0000) $display("FAIL t3_grst_clr got=%b exp=0000", ghost_rst); else n_pass++;
        n_checks++; if (lives !== 3'd2) $display("FAIL t3_lives_keep got=%0d exp=2", lives); else n_pass++;
    endtask

    task automatic test_game_over();
        for (int k = 0; k < 2; k++) begin
            tick_n(60);
            p_dead = 4'b0001;
            @(negedge clk);
            p_dead = 4'b0000;
            n_checks++; if (lives !== 3'(1 - k)) $display("FAIL t4_lives%0d got=%0d exp=%0d", k, lives, 1 - k); else n_pass++;
            tick_n(90);
        end
        n_checks++; if (state !== 3'd4) $display("FAIL t4_over got=%0d exp=4", state); else n_pass++;
        n_checks++; if (game_over !== 1'b1) $display("FAIL t4_go got=%b exp=1", game_over); else n_pass++;
        n_checks++; if (pac_en !== 1'b0 || ghost_en !== 4'b0000) $display("FAIL t4_en got=%b/%b exp=0/0000", pac_en, ghost_en); else n_pass++;
        tick_n(5);
        n_checks++; if (state !== 3'd4) $display("FAIL t4_over_hold got=%0d exp=4", state); else n_pass++;
        press_start();
        n_checks++; if (state !== 3'd1 || lives !== 3'd3 || game_over !== 1'b0)
            $display("FAIL t4_restart got=%0d/%0d/%b exp=1/3/0", state, lives, game_over); else n_pass++;
    endtask

    task automatic test_win();
        tick_n(65);
        pellet_clr = 1'b1;
        p_dead = 4'b0001;
        @(negedge clk);
        pellet_clr = 1'b0;
        p_dead = 4'b0000;
        n_checks++; if (state !== 3'd5) $display("FAIL t5_win got=%0d exp=5", state); else n_pass++;
        n_checks++; if (win !== 1'b1) $display("FAIL t5_flag got=%b exp=1", win); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL t5_lives got=%0d exp=3", lives); else n_pass++;
        n_checks++; if (pac_en !== 1'b0 || ghost_en !== 4'b0000) $display("FAIL t5_en got=%b/%b exp=0/0000", pac_en, ghost_en); else n_pass++;
        press_start();
        n_checks++; if (state !== 3'd1 || win !== 1'b0) $display("FAIL t5_restart got=%0d/%b exp=1/0", state, win); else n_pass++;
    endtask

`ifdef GHOST_FRIGHT_EN
    task automatic test_fright();
        tick_n(160);
        power_eaten = 1'b1;
        @(negedge clk);
        power_eaten = 1'b0;
        n_checks++; if (ghost_mode !== 2'd2) $display("FAIL t6_fright got=%0d exp=2", ghost_mode); else n_pass++;
        tick_n(10);
        p_dead = 4'b0010;
        @(negedge clk);
        n_checks++; if (ghost_rst !== 4'b0010) $display("FAIL t6_grst got=%b exp=0010", ghost_rst); else n_pass++;
        n_checks++; if (state !== 3'd2) $display("FAIL t6_play got=%0d exp=2", state); else n_pass++;
        @(negedge clk);
        n_checks++; if (ghost_rst !== 4'b0000) $display("FAIL t6_grst_once got=%b exp=0000", ghost_rst); else n_pass++;
        n_checks++; if (ghost_en !== 4'b1111 || lives !== 3'd3) $display("FAIL t6_keep got=%b/%0d exp=1111/3", ghost_en, lives); else n_pass++;
        p_dead = 4'b0000;
        tick_n(109);
        n_checks++; if (ghost_mode !== 2'd2) $display("FAIL t6_fright119 got=%0d exp=2", ghost_mode); else n_pass++;
        tick_n(1);
        n_checks++; if (ghost_mode !== 2'd0) $display("FAIL t6_resume got=%0d exp=0", ghost_mode); else n_pass++;
        tick_n(39);
        n_checks++; if (ghost_mode !== 2'd0) $display("FAIL t6_scat39 got=%0d exp=0", ghost_mode); else n_pass++;
        tick_n(1);
        n_checks++; if (ghost_mode !== 2'd1) $display("FAIL t6_chase got=%0d exp=1", ghost_mode); else n_pass++;
    endtask
`else
    task automatic test_power_ignored();
        tick_n(160);
        power_eaten = 1'b1;
        @(negedge clk);
        power_eaten = 1'b0;
        @(negedge clk);
        n_checks++; if (ghost_mode !== 2'd0 || state !== 3'd2) $display("FAIL pwr_ignored got=%0d/%0d exp=0/2", ghost_mode, state); else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        n_checks++; if (state !== 3'd2) $display("FAIL t1_pre got=%0d exp=2", state); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0) $display("FAIL t1_state got=%0d exp=0", state); else n_pass++;
        n_checks++; if (pac_en !== 1'b0 || ghost_en !== 4'b0000) $display("FAIL t1_en got=%b/%b exp=0/0000", pac_en, ghost_en); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL t1_lives got=%0d exp=3", lives); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        tick_n(70);
        n_checks++; if (state !== 3'd0) $display("FAIL t1_idle got=%0d exp=0", state); else n_pass++;
        press_start();
        n_checks++; if (state !== 3'd1) $display("FAIL t1_restart got=%0d exp=1", state); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        clk_s = 1'b0;
        start = 1'b0;
        p_dead = 4'b0000;
        pellet_clr = 1'b0;
        power_eaten = 1'b0;
        test_reset();
        test_release_modes();
        test_death();
        test_game_over();
        test_win();
`ifdef GHOST_FRIGHT_EN
        test_fright();
`else
        test_power_ignored();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
